// File: rtl/maj_bist_pkg.sv
// Shared types and helpers for the majority-netlist BIST controller and its reference model.
package maj_bist_pkg;

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  // Widest vector the popcount helper accepts; narrower vectors are zero-extended by callers.
  localparam int unsigned MaxN = 64;
  localparam int unsigned DefN = 33;
  localparam int unsigned CNTW = $clog2(DefN + 1);

  function automatic int unsigned popcount(input logic [MaxN-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MaxN; i++) begin
      cnt += {31'b0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/maj_bist_if.sv
// Host/DUT-facing bundle of the BIST controller: sweep control, DUT stimulus/response, results.
interface maj_bist_if #(
  parameter int unsigned N    = 33,
  parameter int unsigned ERRW = 32
);
  logic            start;
  logic            abort;
  logic [N-1:0]    last_vec;
  logic [N-1:0]    x;
  logic            y;
  logic            busy;
  logic            done;
  logic            pass;
  logic [ERRW-1:0] err_cnt;
  logic [N-1:0]    first_fail;
  logic            first_fail_vld;

  modport master (
    output start, abort, last_vec, y,
    input  x, busy, done, pass, err_cnt, first_fail, first_fail_vld
  );

  modport slave (
    input  start, abort, last_vec, y,
    output x, busy, done, pass, err_cnt, first_fail, first_fail_vld
  );
endinterface

// File: rtl/maj_ref.sv
// Combinational majority reference: ref_o = 1 when at least THRESH inputs are set.
module maj_ref
  import maj_bist_pkg::*;
#(
  parameter int unsigned N      = 33,
  parameter int unsigned THRESH = (N + 1) / 2
) (
  input  logic [N-1:0] x_i,
  output logic         ref_o
);
  localparam int unsigned CntW = $clog2(N + 1);

  logic [CntW-1:0] cnt;

  always_comb begin
    cnt   = CntW'(popcount(MaxN'(x_i)));
    ref_o = (cnt >= CntW'(THRESH));
  end
endmodule

// File: rtl/maj_bist.sv
// BIST sweep controller: drives ascending vectors into a majority netlist, checks y against
// the popcount reference and records mismatch count and lowest failing vector.
module maj_bist
  import maj_bist_pkg::*;
#(
  parameter int unsigned N      = 33,
  parameter int unsigned THRESH = (N + 1) / 2,
  parameter int unsigned SETTLE = 0,
  parameter int unsigned ERRW   = 32
) (
  input logic       clk_i,
  input logic       rst_ni,
  maj_bist_if.slave bus
);
  // The wait counter runs SETTLE-1..0, giving SETTLE idle cycles before the CHECK cycle.
  localparam logic [3:0] SettleLd = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam state_e     StStep   = (SETTLE == 0) ? StCheck : StSettle;

  state_e          state_q, state_d;
  logic [N-1:0]    x_q, x_d, last_q, last_d, ff_q, ff_d;
  logic [3:0]      wait_q, wait_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            ffv_q, ffv_d, pass_q, pass_d;
  logic            ref_w;

  maj_ref #(.N(N), .THRESH(THRESH)) u_ref (
    .x_i   (x_q),
    .ref_o (ref_w)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    last_d  = last_q;
    wait_d  = wait_q;
    err_d   = err_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start && !bus.abort) begin
          x_d     = '0;
          last_d  = bus.last_vec;
          err_d   = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          wait_d  = SettleLd;
          state_d = StStep;
        end
      end
      StSettle: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (wait_q == 4'd0) begin
          state_d = StCheck;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StCheck: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          if (bus.y != ref_w) begin
            if (err_q != '1) err_d = err_q + ERRW'(1);
            if (!ffv_q) begin
              ff_d  = x_q;
              ffv_d = 1'b1;
            end
          end
          // Terminate on equality so an all-ones last_vec never wraps x.
          if (x_q == last_q) begin
            state_d = StDone;
          end else begin
            x_d     = x_q + N'(1);
            wait_d  = SettleLd;
            state_d = StStep;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    pass_d = (state_d == StDone) && (err_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      x_q     <= '0;
      last_q  <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.x              = x_q;
  assign bus.busy           = (state_q == StSettle) || (state_q == StCheck);
  assign bus.done           = (state_q == StDone);
  assign bus.pass           = pass_q;
  assign bus.err_cnt        = err_q;
  assign bus.first_fail     = ff_q;
  assign bus.first_fail_vld = ffv_q;
endmodule

// File: tb/tb_maj_bist.sv
// Directed bench for maj_bist: golden, stuck-at-0 and inverted DUTs, settle timing, abort,
// mid-sweep reset and counter saturation.
module tb_maj_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_c_n = 1'b0;
  logic [1:0] mode_b = 2'd0;  // 0 golden, 1 stuck-at-0, 2 inverted
  int checks = 0;
  int failures = 0;
  int cnt;
  logic ref_a, ref_b, ref_c, ref_d;

  always #5 clk = ~clk;

  maj_bist_if #(.N(33), .ERRW(32)) if_a ();
  maj_bist_if #(.N(5),  .ERRW(32)) if_b ();
  maj_bist_if #(.N(5),  .ERRW(32)) if_c ();
  maj_bist_if #(.N(5),  .ERRW(4))  if_d ();

  maj_ref #(.N(33), .THRESH(17)) u_ref_a (.x_i(if_a.x), .ref_o(ref_a));
  maj_ref #(.N(5),  .THRESH(3))  u_ref_b (.x_i(if_b.x), .ref_o(ref_b));
  maj_ref #(.N(5),  .THRESH(3))  u_ref_c (.x_i(if_c.x), .ref_o(ref_c));
  maj_ref #(.N(5),  .THRESH(3))  u_ref_d (.x_i(if_d.x), .ref_o(ref_d));

  assign if_a.y = ref_a;
  assign if_b.y = (mode_b == 2'd1) ? 1'b0 : (mode_b == 2'd2) ? ~ref_b : ref_b;
  assign if_c.y = ref_c;
  assign if_d.y = ~ref_d;

  maj_bist #(.N(33), .THRESH(17), .SETTLE(0), .ERRW(32)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_a.slave));
  maj_bist #(.N(5), .THRESH(3), .SETTLE(0), .ERRW(32)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_b.slave));
  maj_bist #(.N(5), .THRESH(3), .SETTLE(2), .ERRW(32)) u_c (
    .clk_i(clk), .rst_ni(rst_c_n), .bus(if_c.slave));
  maj_bist #(.N(5), .THRESH(3), .SETTLE(0), .ERRW(4)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_d.slave));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_a.start = 0; if_a.abort = 0; if_a.last_vec = '0;
    if_b.start = 0; if_b.abort = 0; if_b.last_vec = '0;
    if_c.start = 0; if_c.abort = 0; if_c.last_vec = '0;
    if_d.start = 0; if_d.abort = 0; if_d.last_vec = '0;
    repeat (3) tick();
    check_eq("rst_busy", 64'(if_b.busy), 64'd0);
    check_eq("rst_done", 64'(if_b.done), 64'd0);
    check_eq("rst_pass", 64'(if_b.pass), 64'd0);
    check_eq("rst_err",  64'(if_b.err_cnt), 64'd0);
    check_eq("rst_x",    64'(if_b.x), 64'd0);
    check_eq("rst_ffv",  64'(if_b.first_fail_vld), 64'd0);
    rst_n = 1'b1;
    rst_c_n = 1'b1;
    tick();

    // N=33 golden sweep of 0..1023
    if_a.last_vec = 33'd1023;
    if_a.start = 1; tick(); if_a.start = 0;
    check_eq("a_busy_start", 64'(if_a.busy), 64'd1);
    cnt = 0;
    while (!if_a.done && cnt < 1100) begin tick(); cnt++; end
    check_eq("a_latency", 64'(cnt), 64'd1024);
    check_eq("a_pass", 64'(if_a.pass), 64'd1);
    check_eq("a_err",  64'(if_a.err_cnt), 64'd0);
    check_eq("a_ffv",  64'(if_a.first_fail_vld), 64'd0);
    check_eq("a_busy_end", 64'(if_a.busy), 64'd0);
    check_eq("a_x_hold", 64'(if_a.x), 64'd1023);

    // N=5 stuck-at-0: 16 vectors with popcount >= 3
    mode_b = 2'd1;
    if_b.last_vec = 5'd31;
    if_b.start = 1; tick(); if_b.start = 0;
    cnt = 0;
    while (!if_b.done && cnt < 100) begin tick(); cnt++; end
    check_eq("b0_latency", 64'(cnt), 64'd32);
    check_eq("b0_err",  64'(if_b.err_cnt), 64'd16);
    check_eq("b0_ff",   64'(if_b.first_fail), 64'd7);
    check_eq("b0_ffv",  64'(if_b.first_fail_vld), 64'd1);
    check_eq("b0_pass", 64'(if_b.pass), 64'd0);

    // Inverted DUT, restarted from DONE: statistics must clear on start
    mode_b = 2'd2;
    if_b.start = 1; tick(); if_b.start = 0;
    check_eq("bi_err_clr",  64'(if_b.err_cnt), 64'd0);
    check_eq("bi_ffv_clr",  64'(if_b.first_fail_vld), 64'd0);
    check_eq("bi_done_clr", 64'(if_b.done), 64'd0);
    cnt = 0;
    while (!if_b.done && cnt < 100) begin tick(); cnt++; end
    check_eq("bi_err",  64'(if_b.err_cnt), 64'd32);
    check_eq("bi_ff",   64'(if_b.first_fail), 64'd0);
    check_eq("bi_ffv",  64'(if_b.first_fail_vld), 64'd1);
    check_eq("bi_pass", 64'(if_b.pass), 64'd0);

    // Golden: start while busy ignored, then abort at vector 7
    mode_b = 2'd0;
    if_b.start = 1; tick(); if_b.start = 0;
    repeat (3) tick();
    if_b.start = 1; tick(); if_b.start = 0;
    check_eq("bg_no_restart", 64'(if_b.x), 64'd4);
    check_eq("bg_busy", 64'(if_b.busy), 64'd1);
    cnt = 0;
    while (if_b.x != 5'd7 && cnt < 40) begin tick(); cnt++; end
    check_eq("bg_at7", 64'(if_b.x), 64'd7);
    if_b.abort = 1; tick(); if_b.abort = 0;
    check_eq("abort_busy", 64'(if_b.busy), 64'd0);
    check_eq("abort_done", 64'(if_b.done), 64'd0);
    check_eq("abort_pass", 64'(if_b.pass), 64'd0);
    if_b.abort = 1; if_b.start = 1; tick(); if_b.abort = 0; if_b.start = 0;
    check_eq("abst_busy", 64'(if_b.busy), 64'd0);
    tick();
    check_eq("abst_busy2", 64'(if_b.busy), 64'd0);
    check_eq("abst_done",  64'(if_b.done), 64'd0);

    // SETTLE=2: reset at vector 10, then full sweep
    if_c.last_vec = 5'd31;
    if_c.start = 1; tick(); if_c.start = 0;
    cnt = 0;
    while (if_c.x != 5'd10 && cnt < 100) begin tick(); cnt++; end
    check_eq("c_at10", 64'(if_c.x), 64'd10);
    #2 rst_c_n = 1'b0;
    #1;
    check_eq("c_rst_x",    64'(if_c.x), 64'd0);
    check_eq("c_rst_busy", 64'(if_c.busy), 64'd0);
    check_eq("c_rst_done", 64'(if_c.done), 64'd0);
    check_eq("c_rst_err",  64'(if_c.err_cnt), 64'd0);
    #1 rst_c_n = 1'b1;
    tick();
    if_c.start = 1; tick(); if_c.start = 0;
    cnt = 0;
    while (!if_c.done && cnt < 200) begin tick(); cnt++; end
    check_eq("c_latency", 64'(cnt), 64'd96);
    check_eq("c_pass", 64'(if_c.pass), 64'd1);

    // ERRW=4 inverted: saturate at 15
    if_d.last_vec = 5'd31;
    if_d.start = 1; tick(); if_d.start = 0;
    cnt = 0;
    while (!if_d.done && cnt < 100) begin tick(); cnt++; end
    check_eq("d_done", 64'(if_d.done), 64'd1);
    check_eq("d_err_sat", 64'(if_d.err_cnt), 64'd15);
    check_eq("d_pass", 64'(if_d.pass), 64'd0);
    check_eq("d_ff", 64'(if_d.first_fail), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
